// File: rtl/dacspi_pkg.sv
// Shared types and width helpers for the multi-channel SPI DAC writer.
package dacspi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4,
        LDAC  = 3'd5
    } state_t;

    // Width of the channel index; a single DAC still gets a 1-bit index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/dacspi_mc_if.sv
// Write-side handshake bundle for dacspi_mc: {chan, data} words with valid/ready.
interface dacspi_mc_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 1
) ();
    logic [DATA_W-1:0] wr_data;
    logic [CH_W-1:0]   wr_chan;
    logic              wr;
    logic              wr_ready;

    modport master (output wr_data, output wr_chan, output wr, input wr_ready);
    modport slave  (input wr_data, input wr_chan, input wr, output wr_ready);
endinterface

// File: rtl/dacspi_mc_tick.sv
// Phase timer: strobes on the last clk cycle of every CLK_DIV-cycle phase.
module dacspi_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic strobe
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;

    assign strobe = (cnt_reg == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || restart || strobe) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/dacspi_mc.sv
// Multi-channel SPI DAC writer with a one-word holding buffer (CPHA=0).
// Optional DACSPI_MC_LDAC_EN adds an spi_ldac_n strobe after each idle-bound frame.
module dacspi_mc
    import dacspi_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int CLK_DIV  = 1,
    parameter bit CPOL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    dacspi_mc_if.slave          wr_bus,
    output logic                busy,
    output logic                done,
    output logic [CHANNELS-1:0] spi_cs_n,
    output logic                spi_sclk,
    output logic                spi_sdout
`ifdef DACSPI_MC_LDAC_EN
    ,
    output logic                spi_ldac_n
`endif
);
    localparam int CH_W = ch_w(CHANNELS);
    localparam int BC_W = bit_cnt_w(DATA_W);

    state_t              state_reg;
    logic                buf_full_reg;
    logic [CH_W-1:0]     buf_chan_reg;
    logic [DATA_W-1:0]   buf_data_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [BC_W-1:0]     bit_cnt_reg;
    logic                half_reg;
    logic [CHANNELS-1:0] cs_n_reg;
    logic                sclk_reg;
    logic                done_reg;
    logic [CHANNELS-1:0] cs_sel_n;
    logic                tick;
    logic                accept;
    logic                chan_ok;
    logic                load;
`ifdef DACSPI_MC_LDAC_EN
    logic                ldac_n_reg;
    assign spi_ldac_n = ldac_n_reg;
`endif

    assign wr_bus.wr_ready = !buf_full_reg;
    assign accept  = wr_bus.wr && !buf_full_reg;
    assign chan_ok = (32'(wr_bus.wr_chan) < CHANNELS);
    // The buffered word starts a frame from IDLE, or back-to-back at the end of GAP.
    assign load    = buf_full_reg && ((state_reg == IDLE) || (state_reg == GAP && tick));

    assign busy      = (state_reg != IDLE) || buf_full_reg;
    assign done      = done_reg;
    assign spi_cs_n  = cs_n_reg;
    assign spi_sclk  = sclk_reg;
    assign spi_sdout = shift_reg[DATA_W-1];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cs
        assign cs_sel_n[gi] = (buf_chan_reg != CH_W'(gi));
    end

    dacspi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (state_reg == IDLE),
        .strobe  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            buf_full_reg <= 1'b0;
            buf_chan_reg <= '0;
            buf_data_reg <= '0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            half_reg     <= 1'b0;
            cs_n_reg     <= '1;
            sclk_reg     <= CPOL;
            done_reg     <= 1'b0;
`ifdef DACSPI_MC_LDAC_EN
            ldac_n_reg   <= 1'b1;
`endif
        end else begin
            done_reg <= 1'b0;

            // Out-of-range channels complete the handshake but never load.
            if (accept && chan_ok) begin
                buf_full_reg <= 1'b1;
                buf_chan_reg <= wr_bus.wr_chan;
                buf_data_reg <= wr_bus.wr_data;
            end else if (load) begin
                buf_full_reg <= 1'b0;
            end

            if (load) begin
                state_reg <= LEAD;
                shift_reg <= buf_data_reg;
                cs_n_reg  <= cs_sel_n;
                sclk_reg  <= CPOL;
            end else begin
                case (state_reg)
                    LEAD: if (tick) begin
                        state_reg   <= SHIFT;
                        half_reg    <= 1'b0;
                        bit_cnt_reg <= '0;
                    end
                    SHIFT: if (tick) begin
                        if (!half_reg) begin
                            half_reg <= 1'b1;
                            sclk_reg <= ~CPOL;
                        end else begin
                            half_reg <= 1'b0;
                            sclk_reg <= CPOL;
                            // The LSB stays on SDOUT through TRAIL, so no shift after it.
                            if (bit_cnt_reg == BC_W'(DATA_W - 1)) begin
                                state_reg <= TRAIL;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                shift_reg   <= {shift_reg[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    TRAIL: if (tick) begin
                        state_reg <= GAP;
                        cs_n_reg  <= '1;
                        shift_reg <= '0;
                        done_reg  <= 1'b1;
                    end
`ifdef DACSPI_MC_LDAC_EN
                    GAP: if (tick) begin
                        state_reg  <= LDAC;
                        ldac_n_reg <= 1'b0;
                        half_reg   <= 1'b0;
                    end
                    LDAC: if (tick) begin
                        if (!half_reg) begin
                            half_reg <= 1'b1;
                        end else begin
                            ldac_n_reg <= 1'b1;
                            state_reg  <= IDLE;
                        end
                    end
`else
                    GAP: if (tick) begin
                        state_reg <= IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/dacspi_mc.md
Name: dacspi_mc

Overview:
- Parametrised, multi-channel successor to the single-channel 16-bit SPI DAC writer. It accepts (channel, sample) words over a valid/ready handshake.
- Buffers one pending word while another is shifting.
- Serialises each word MSB-first on a shared SCLK/SDOUT, with one active-low chip select per DAC.
- Sits between the sample pipeline and the off-chip DAC bank.

Parameters:
- DATA_W, 16: bits per SPI frame.
- CHANNELS, 2: number of DACs, one spi_cs_n bit each; range 1..16.
- CLK_DIV, 1: clk cycles per SCLK half-period; must be >= 1.
- CPOL, 0: SCLK idle level. Data always changes on the trailing edge and is sampled by the DAC on the leading edge (CPHA=0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_data  in  DATA_W  sample to send
- wr_chan  in  CH_W=max(1,$clog2(CHANNELS))  target DAC index
- wr  in  1  write valid
- wr_ready  out  1  holding buffer empty; write accepted when wr && wr_ready
- busy  out  1  frame in progress or word pending
- done  out  1  one-cycle pulse when cs_n deasserts at end of a frame
- spi_cs_n  out  CHANNELS  per-DAC chip select, active low
- spi_sclk  out  1  serial clock
- spi_sdout  out  1  serial data

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: spi_cs_n all 1, spi_sclk=CPOL, spi_sdout=0, wr_ready=1, busy=0, done=0, holding buffer empty, FSM=IDLE.
  - Reset mid-frame aborts the frame immediately; cs_n is high in the cycle after rst is sampled.
- Holding buffer:
  - One entry of {chan, data}.
  - Loaded on an accepted write; wr_ready=0 while full.
  - Writes with wr_chan >= CHANNELS are accepted and discarded: buffer not loaded, no frame.
- FSM states: IDLE, LEAD, SHIFT, TRAIL, GAP. A tick counter counts CLK_DIV clk cycles per phase.
- IDLE:
  - If buffer full: move it to the shift register, free the buffer (wr_ready=1 next cycle), go to LEAD.
  - A write accepted in IDLE starts LEAD the cycle after the buffer loads.
  - Buffer full and new wr in the same cycle: the new write is refused because wr_ready=0.
- LEAD (CLK_DIV cycles):
  - cs_n[chan]=0, SCLK=CPOL, SDOUT=data MSB.
- SHIFT (DATA_W bits, 2*CLK_DIV cycles per bit):
  - First half: SCLK=CPOL.
  - Second half: SCLK=~CPOL (leading edge).
  - At the end of each bit, SCLK returns to CPOL and the shift register advances so the next bit appears on SDOUT.
  - After the LSB bit period, go to TRAIL.
- TRAIL (CLK_DIV cycles):
  - SCLK=CPOL, cs_n still low, SDOUT holds the LSB.
- GAP (CLK_DIV cycles):
  - cs_n all high, SDOUT=0; done=1 in the first GAP cycle.
  - Then IDLE, or straight to LEAD if the buffer is full (back-to-back frames, minimum CS-high time of CLK_DIV).
- Timing and invariants:
  - cs_n low time = CLK_DIV*(2*DATA_W+2) cycles; DATA_W=16, CLK_DIV=1 gives 34.
  - Only one cs_n bit is ever low.
  - SCLK shows exactly DATA_W leading edges per frame.
- busy = (state != IDLE) || buffer full.

Optional Feature:
- Macro: DACSPI_MC_LDAC_EN.
- When defined:
  - Adds output spi_ldac_n (1 bit, reset 1).
  - After a frame's GAP, if the buffer is empty, FSM enters an LDAC state.
  - spi_ldac_n=0 for 2*CLK_DIV cycles, then returns to IDLE; this updates all DAC outputs simultaneously.
  - busy stays high during LDAC.
  - A write arriving during LDAC waits until LDAC completes.
- When undefined: no port, no LDAC state.

Decomposition:
- Package dacspi_pkg:
  - State enum (IDLE, LEAD, SHIFT, TRAIL, GAP, LDAC).
  - CH_W width function.
  - Localparam for bit-counter width $clog2(DATA_W+1).
- Sub-module dacspi_tick: CLK_DIV phase counter producing a one-cycle end-of-phase strobe, restartable by the FSM.

Test Plan:
- Reset, then wr=1 for 1 cycle with data 16'hA6CD, chan 0, CLK_DIV=1 → cs_n=2'b10 for 34 cycles. SDOUT sampled at the 16 rising SCLK edges reads 1010_0110_1100_1101; done pulses once; cs_n back to 2'b11.
- Two writes back-to-back (16'h1234 to chan 1, then 16'h00FF to chan 0) → second accepted while first shifts. Exactly one GAP cycle of cs_n=2'b11 between frames; wr_ready=0 during a third attempt before the first frame ends.
- wr_chan=2 with CHANNELS=2 → handshake completes, no cs_n activity, done stays 0, busy stays 0.
- CLK_DIV=3, CPOL=1 → SCLK idles high, half-period 3 cycles, cs_n low 102 cycles; data still correct on falling edges.
- rst asserted at bit 7 of a frame → next cycle cs_n all 1, SCLK=CPOL, wr_ready=1; a following write sends a full clean frame.
- DACSPI_MC_LDAC_EN defined: single write → spi_ldac_n low for 2 cycles starting after GAP, busy high throughout.
